// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-unit definitions: state encoding, reset vector, condition codes.
// Also imported by the control-signal generator.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  // Word offset: sign-extend imm22, then scale by 4.
  function automatic logic [31:0] branch_offset(
    input logic [21:0] imm
  );
    return {{8{imm[21]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_cond_eval.sv
// Combinational branch-condition evaluator.
// Flags are packed N,Z,C,V from bit 3 down to bit 0.
module cond_eval
  import instr_fetch_unit_pkg::*;
(
  input  logic [3:0] NZCV,
  input  logic [3:0] COND,
  output logic       RESULT
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign {n, z, c, v} = NZCV;

  always_comb begin
    RESULT = 1'b0;
    unique case (cond_t'(COND))
      COND_EQ: RESULT = z;
      COND_NE: RESULT = !z;
      COND_CS: RESULT = c;
      COND_CC: RESULT = !c;
      COND_MI: RESULT = n;
      COND_PL: RESULT = !n;
      COND_VS: RESULT = v;
      COND_VC: RESULT = !v;
      COND_HI: RESULT = c && !z;
      COND_LS: RESULT = !c || z;
      COND_GE: RESULT = (n == v);
      COND_LT: RESULT = (n != v);
      COND_GT: RESULT = !z && (n == v);
      COND_LE: RESULT = z || (n != v);
      COND_AL: RESULT = 1'b1;
      COND_NV: RESULT = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE -> FETCH -> EXEC sequencer with PC,
// instruction register, architectural flags and branch resolution.
module instr_fetch_unit (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] INSTR,
  output logic [9:0]  OPCODE,
  output logic        VALID,
  output logic [31:0] PC,
  input  logic        STALL,
  input  logic        R_BRANCH,
  input  logic        C_BRANCH,
  input  logic [3:0]  COND,
  input  logic [3:0]  NZCVWRITE,
  input  logic [3:0]  ALU_NZCV,
  input  logic [31:0] RS_DATA,
  output logic [3:0]  NZCV,
  output logic        TAKEN
);

  import instr_fetch_unit_pkg::*;

  state_t      state;
  state_t      state_nxt;
  logic        armed;
  logic        cond_ok;
  logic        exec_done;
  logic [31:0] pc_nxt;

  cond_eval u_cond (
    .NZCV   (NZCV),
    .COND   (COND),
    .RESULT (cond_ok)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Holds IDLE for one full cycle after reset release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) armed <= 1'b0;
    else     armed <= (state == ST_IDLE);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (armed)    state_nxt = ST_FETCH;
      ST_FETCH: if (IMEM_ACK) state_nxt = ST_EXEC;
      ST_EXEC:  if (!STALL)   state_nxt = ST_FETCH;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    IMEM_REQ = 1'b0;
    VALID    = 1'b0;
    unique case (state)
      ST_FETCH: IMEM_REQ = 1'b1;
      ST_EXEC:  VALID    = 1'b1;
      default: ;
    endcase
  end

  assign exec_done = (state == ST_EXEC) && !STALL;

  always_comb begin
    pc_nxt = PC + 32'd4;
    if (R_BRANCH)
      pc_nxt = RS_DATA & 32'hFFFF_FFFC;
    else if (C_BRANCH && cond_ok)
      pc_nxt = PC + branch_offset(INSTR[21:0]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      INSTR <= '0;
    end else if (state == ST_FETCH && IMEM_ACK) begin
      INSTR <= IMEM_RDATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PC   <= RESET_VECTOR;
      NZCV <= 4'b0000;
    end else if (exec_done) begin
      PC   <= pc_nxt;
      NZCV <= (ALU_NZCV & NZCVWRITE) | (NZCV & ~NZCVWRITE);
    end
  end

  assign IMEM_ADDR = PC;
  assign OPCODE    = INSTR[31:22];
  assign TAKEN     = VALID && (R_BRANCH || (C_BRANCH && cond_ok));

endmodule
